// File: rtl/rtc_access_arbiter.sv
// Purpose: round-robin arbiter that lets two requesters share one RTC register access engine.
// Latency: enable rises the cycle after a grant; ack pulses the cycle after engine done or timeout.
// Backpressure: requests wait (valid held) while busy; a grant is only issued from IDLE.
module rtc_access_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_count,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  input  logic [7:0] req0_wdata,
  input  logic       req0_wr,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  input  logic [7:0] req1_wdata,
  input  logic       req1_wr,
  output logic       req0_ack,
  output logic       req1_ack,
  output logic       resp_err,
  output logic [7:0] resp_rdata,
  output logic [7:0] out_addr_ram_rtc,
  output logic [7:0] out_dato,
  output logic       out_funcion_w_r,
  output logic       out_en_funcion_rtc,
  input  logic       in_flag_done,
  input  logic [7:0] in_dato_rtc,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Counter value seen in the last permitted BUSY cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic       last_grant_q;
  logic       grant_q;
  logic       grant_d;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       wr_q;
  logic       en_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       err_q;
  logic [7:0] rdata_q;
  logic       busy_q;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_d = last_grant_q;
    if (req0_valid && req1_valid) grant_d = ~last_grant_q;
    else if (req0_valid)          grant_d = 1'b0;
    else if (req1_valid)          grant_d = 1'b1;
  end

  // Main FSM; every output below is a register (or gated by one) so nothing glitches to the engine.
  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state_q      <= IDLE;
      cnt_q        <= 8'h00;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      wr_q         <= 1'b0;
      en_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 8'h00;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            addr_q       <= grant_d ? req1_addr  : req0_addr;
            wdata_q      <= grant_d ? req1_wdata : req0_wdata;
            wr_q         <= grant_d ? req1_wr    : req0_wr;
            cnt_q        <= 8'h00;
            en_q         <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 8'h01;
          // Done wins over a coinciding timeout, so it is tested first.
          if (in_flag_done) begin
            rdata_q <= wr_q ? 8'h00 : in_dato_rtc;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            state_q <= RESP;
          end else if (cnt_q == TO_LAST) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b1;
            en_q    <= 1'b0;
            ack0_q  <= ~grant_q;
            ack1_q  <= grant_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          en_q    <= 1'b0;
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Engine command fields are only non-zero while the enable is up.
  assign out_addr_ram_rtc   = en_q ? addr_q  : 8'h00;
  assign out_dato           = en_q ? wdata_q : 8'h00;
  assign out_funcion_w_r    = en_q & wr_q;
  assign out_en_funcion_rtc = en_q;
  assign req0_ack           = ack0_q;
  assign req1_ack           = ack1_q;
  assign resp_err           = err_q;
  assign resp_rdata         = rdata_q;
  assign busy               = busy_q;

endmodule
